// File: rtl/disp_text_buffer.sv
// rtl/disp_text_buffer.sv - text-mode character buffer with blinking cursor overlay; optional scrolling under DISP_TEXT_SCROLL_EN
module disp_text_buffer #(
  parameter int BUFFER_WIDTH = 16,
  parameter int ASCII_WIDTH  = 8,
  parameter int GRID_ROW     = 5,
  parameter int GRID_COL     = 10,
  parameter int BLINK_CYCLES = 25000000,
  localparam int CIDX_W = (BUFFER_WIDTH - ASCII_WIDTH) / 2,
  localparam int XW     = $clog2(GRID_COL),
  localparam int YW     = $clog2(GRID_ROW)
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ASCII_WIDTH-1:0]  ascii,
  input  logic [CIDX_W-1:0]       colorIndexF,
  input  logic [CIDX_W-1:0]       colorIndexB,
  input  logic [XW-1:0]           chPos_x,
  input  logic [YW-1:0]           chPos_y,
  output logic [BUFFER_WIDTH-1:0] bufferBundle,
  output logic [XW-1:0]           cursor_x,
  output logic [YW-1:0]           cursor_y
);

  localparam int N  = GRID_ROW * GRID_COL;
  localparam int IW = $clog2(N);
  localparam int BW = $clog2(BLINK_CYCLES);

  localparam logic [ASCII_WIDTH-1:0] C_CLS   = ASCII_WIDTH'(8'h02);
  localparam logic [ASCII_WIDTH-1:0] C_LEFT  = ASCII_WIDTH'(8'h11);
  localparam logic [ASCII_WIDTH-1:0] C_UP    = ASCII_WIDTH'(8'h12);
  localparam logic [ASCII_WIDTH-1:0] C_DOWN  = ASCII_WIDTH'(8'h13);
  localparam logic [ASCII_WIDTH-1:0] C_RIGHT = ASCII_WIDTH'(8'h14);
  localparam logic [ASCII_WIDTH-1:0] C_ENTER = ASCII_WIDTH'(8'h0D);
  localparam logic [ASCII_WIDTH-1:0] C_BS    = ASCII_WIDTH'(8'h7F);
  localparam logic [ASCII_WIDTH-1:0] GLYPH_CURSOR = ASCII_WIDTH'(127);
  localparam logic [XW-1:0] X_LAST = XW'(GRID_COL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GRID_ROW - 1);

`ifdef DISP_TEXT_SCROLL_EN
  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL} state_t;
`else
  typedef enum logic [0:0] {CLEAR, IDLE} state_t;
`endif

  state_t                  state, state_n;
  logic [IW-1:0]           cnt, cnt_n;
  logic [XW-1:0]           cur_x, cx_n, left_x, right_x;
  logic [YW-1:0]           cur_y, cy_n, left_y, right_y, up_y, down_y, top_row;
  logic                    accept, we, nl, phase, rd_in_range;
  logic [IW-1:0]           w_idx, rd_idx;
  logic [BUFFER_WIDTH-1:0] w_data, blank_cell, rd_cell;
  logic [BUFFER_WIDTH-1:0] mem [N];
  logic [BW-1:0]           blink_cnt;

  // Logical row -> physical row via the scroll offset, then linear cell index
  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                             input logic [YW-1:0] top);
    int p;
    p = int'(y) + int'(top);
    if (p >= GRID_ROW) p = p - GRID_ROW;
    return IW'(p * GRID_COL + int'(x));
  endfunction

  assign wr_ready   = (state == IDLE);
  assign accept     = wr_valid && wr_ready;
  assign cursor_x   = cur_x;
  assign cursor_y   = cur_y;
  assign blank_cell = {colorIndexB, colorIndexF, {ASCII_WIDTH{1'b0}}};

  assign up_y    = (cur_y == '0) ? Y_LAST : cur_y - YW'(1);
  assign down_y  = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
  assign left_x  = (cur_x == '0) ? X_LAST : cur_x - XW'(1);
  assign left_y  = (cur_x == '0) ? up_y : cur_y;
  assign right_x = (cur_x == X_LAST) ? '0 : cur_x + XW'(1);
  assign right_y = (cur_x == X_LAST) ? down_y : cur_y;

`ifdef DISP_TEXT_SCROLL_EN
  logic [YW-1:0] top_n;
`else
  assign top_row = '0;
`endif

  // Next-state, cursor movement and the single cell write port
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cx_n    = cur_x;
    cy_n    = cur_y;
    we      = 1'b0;
    w_idx   = '0;
    w_data  = blank_cell;
    nl      = 1'b0;
`ifdef DISP_TEXT_SCROLL_EN
    top_n   = top_row;
`endif
    case (state)
      CLEAR: begin
        we    = 1'b1;
        w_idx = cnt;
        if (cnt == IW'(N - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + IW'(1);
        end
      end
`ifdef DISP_TEXT_SCROLL_EN
      // top_row is already advanced, so the bottom logical row is the old top row
      SCROLL: begin
        we    = 1'b1;
        w_idx = cell_idx(XW'(cnt), Y_LAST, top_row);
        if (cnt == IW'(GRID_COL - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + IW'(1);
        end
      end
`endif
      default: begin
        if (accept) begin
          case (ascii)
            C_CLS: begin
              state_n = CLEAR;
              cnt_n   = '0;
              cx_n    = '0;
              cy_n    = '0;
`ifdef DISP_TEXT_SCROLL_EN
              top_n   = '0;
`endif
            end
            C_LEFT:  begin cx_n = left_x;  cy_n = left_y;  end
            C_RIGHT: begin cx_n = right_x; cy_n = right_y; end
            C_UP:    cy_n = up_y;
            C_DOWN:  cy_n = down_y;
            C_ENTER: nl = 1'b1;
            C_BS: begin
              if (cur_x != '0 || cur_y != '0) begin
                cx_n  = left_x;
                cy_n  = left_y;
                we    = 1'b1;
                w_idx = cell_idx(left_x, left_y, top_row);
              end
            end
            default: begin
              we     = 1'b1;
              w_idx  = cell_idx(cur_x, cur_y, top_row);
              w_data = {colorIndexB, colorIndexF, ascii};
              if (cur_x == X_LAST) nl = 1'b1;
              else                 cx_n = cur_x + XW'(1);
            end
          endcase
          if (nl) begin
            cx_n = '0;
            if (cur_y == Y_LAST) begin
`ifdef DISP_TEXT_SCROLL_EN
              cy_n    = Y_LAST;
              top_n   = (top_row == Y_LAST) ? '0 : top_row + YW'(1);
              state_n = SCROLL;
              cnt_n   = '0;
`else
              cy_n    = '0;
`endif
            end else begin
              cy_n = cur_y + YW'(1);
            end
          end
        end
      end
    endcase
  end

  // Control state, clear/scroll index and cursor registers
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cur_x <= cx_n;
      cur_y <= cy_n;
    end
  end

`ifdef DISP_TEXT_SCROLL_EN
  // Scroll offset: logical row 0 lives at physical row top_row
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) top_row <= '0;
    else        top_row <= top_n;
  end
`endif

  // Cell array; contents are initialised by the CLEAR sweep, not by reset
  always_ff @(posedge clk_pix) begin
    if (we) mem[w_idx] <= w_data;
  end

  // Blink phase restarts visible whenever a code is taken
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (accept) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign rd_in_range = (int'(chPos_x) < GRID_COL) && (int'(chPos_y) < GRID_ROW);
  assign rd_idx      = rd_in_range ? cell_idx(chPos_x, chPos_y, top_row) : '0;

  // Renderer lookup with the cursor glyph overlaid on the fly
  always_comb begin
    rd_cell = '0;
    if (rd_in_range) begin
      rd_cell = mem[rd_idx];
      if (chPos_x == cur_x && chPos_y == cur_y && phase)
        rd_cell[ASCII_WIDTH-1:0] = GLYPH_CURSOR;
    end
  end

  // Registered read port
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) bufferBundle <= '0;
    else        bufferBundle <= rd_cell;
  end

endmodule
